stm32_bus_master: RTL and testbench



---
 rtl/stm32_bus_master.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_stm32_bus_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stm32_bus_master.sv
// Initiator end of the 8-bit DATA_SYNC/DATA_BUS link: sends a command byte, streams
// write bytes, turns the bus around to collect read bytes, then holds an idle gap.
module stm32_bus_master #(
    parameter int unsigned IDLE_GAP        = 1,
    parameter logic [7:0]  BUSTEST_PATTERN = 8'hA5
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_code,
    input  logic [103:0] params_in,
    input  logic [31:0]  tx_i_in,
    input  logic [31:0]  tx_q_in,
    output logic         DATA_SYNC,
    output logic [7:0]   DATA_BUS_OUT,
    output logic         DATA_BUS_OE,
    input  logic [7:0]   DATA_BUS_IN,
    output logic         busy,
    output logic         rsp_valid,
    output logic [2:0]   rsp_cmd,
    output logic         cmd_error,
    output logic         adc_otr,
    output logic         dac_otr,
    output logic [15:0]  adc_min,
    output logic [15:0]  adc_max,
    output logic [31:0]  rx1_i,
    output logic [31:0]  rx1_q,
    output logic [31:0]  rx2_i,
    output logic [31:0]  rx2_q,
    output logic [7:0]   bustest_echo,
    output logic         bustest_ok
);

    localparam int unsigned SHIFT_W = 104;
    localparam int unsigned CNT_W   = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SYNC  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_TURN  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [2:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               sync_q, sync_d;
    logic               oe_q, oe_d;
    logic [7:0]         bus_q, bus_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2:0]         rsp_cmd_q, rsp_cmd_d;
    logic               err_q, err_d;
    logic               adc_otr_q, adc_otr_d;
    logic               dac_otr_q, dac_otr_d;
    logic [15:0]        adc_min_q, adc_min_d;
    logic [15:0]        adc_max_q, adc_max_d;
    logic [31:0]        rx1_i_q, rx1_i_d;
    logic [31:0]        rx1_q_q, rx1_q_d;
    logic [31:0]        rx2_i_q, rx2_i_d;
    logic [31:0]        rx2_q_q, rx2_q_d;
    logic [7:0]         echo_q, echo_d;
    logic               ok_q, ok_d;

    // Index of the final byte in the write / read phase of each command.
    function automatic logic [CNT_W-1:0] write_last(input logic [2:0] code);
        case (code)
            3'd1:    return CNT_W'(12);
            3'd3:    return CNT_W'(7);
            default: return CNT_W'(0);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] read_last(input logic [2:0] code);
        case (code)
            3'd2:    return CNT_W'(4);
            3'd4:    return CNT_W'(15);
            default: return CNT_W'(0);
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sync_d      = 1'b0;
        oe_d        = 1'b0;
        bus_d       = 8'h00;
        rsp_valid_d = 1'b0;
        rsp_cmd_d   = rsp_cmd_q;
        err_d       = 1'b0;
        adc_otr_d   = adc_otr_q;
        dac_otr_d   = dac_otr_q;
        adc_min_d   = adc_min_q;
        adc_max_d   = adc_max_q;
        rx1_i_d     = rx1_i_q;
        rx1_q_d     = rx1_q_q;
        rx2_i_d     = rx2_i_q;
        rx2_q_d     = rx2_q_q;
        echo_d      = echo_q;
        ok_d        = ok_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    code_d = cmd_code;
                    cnt_d  = '0;
                    if (cmd_code == 3'd7) begin
                        err_d   = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_SYNC;
                        sync_d  = 1'b1;
                        oe_d    = 1'b1;
                        bus_d   = {5'b00000, cmd_code};
                        case (cmd_code)
                            3'd0:    shift_d = {BUSTEST_PATTERN, 96'h0};
                            3'd1:    shift_d = params_in;
                            3'd3:    shift_d = {tx_q_in, tx_i_in, 40'h0};
                            default: shift_d = '0;
                        endcase
                    end
                end
            end
            S_SYNC: begin
                case (code_q)
                    3'd0, 3'd1, 3'd3: begin
                        state_d = S_WRITE;
                        oe_d    = 1'b1;
                        bus_d   = shift_q[SHIFT_W-1 -: 8];
                        shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                        cnt_d   = '0;
                    end
                    3'd2, 3'd4: state_d = S_TURN;
                    default: begin
                        state_d     = S_GAP;
                        rsp_valid_d = 1'b1;
                        rsp_cmd_d   = code_q;
                        cnt_d       = '0;
                    end
                endcase
            end
            S_WRITE: begin
                if (cnt_q == write_last(code_q)) begin
                    cnt_d = '0;
                    // Bus test turns around after its single pattern byte to read the echo.
                    if (code_q == 3'd0) begin
                        state_d = S_READ;
                    end else begin
                        state_d     = S_GAP;
                        rsp_valid_d = 1'b1;
                        rsp_cmd_d   = code_q;
                    end
                end else begin
                    cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                    oe_d    = 1'b1;
                    bus_d   = shift_q[SHIFT_W-1 -: 8];
                    shift_d = {shift_q[SHIFT_W-9:0], 8'h00};
                end
            end
            S_TURN: begin
                state_d = S_READ;
                cnt_d   = '0;
            end
            S_READ: begin
                case (code_q)
                    3'd0: begin
                        echo_d = DATA_BUS_IN;
                        ok_d   = (DATA_BUS_IN == BUSTEST_PATTERN);
                    end
                    3'd2: begin
                        case (cnt_q)
                            4'd0: begin
                                adc_otr_d = DATA_BUS_IN[0];
                                dac_otr_d = DATA_BUS_IN[1];
                            end
                            4'd1, 4'd2: adc_min_d = {adc_min_q[7:0], DATA_BUS_IN};
                            4'd3, 4'd4: adc_max_d = {adc_max_q[7:0], DATA_BUS_IN};
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        // Four 32-bit words, each shifted in MSB first.
                        case (cnt_q[3:2])
                            2'd0:    rx1_q_d = {rx1_q_q[23:0], DATA_BUS_IN};
                            2'd1:    rx1_i_d = {rx1_i_q[23:0], DATA_BUS_IN};
                            2'd2:    rx2_q_d = {rx2_q_q[23:0], DATA_BUS_IN};
                            default: rx2_i_d = {rx2_i_q[23:0], DATA_BUS_IN};
                        endcase
                    end
                    default: ;
                endcase
                if (cnt_q == read_last(code_q)) begin
                    state_d     = S_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_cmd_d   = code_q;
                    cnt_d       = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            sync_q      <= 1'b0;
            oe_q        <= 1'b0;
            bus_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_cmd_q   <= '0;
            err_q       <= 1'b0;
            adc_otr_q   <= 1'b0;
            dac_otr_q   <= 1'b0;
            adc_min_q   <= '0;
            adc_max_q   <= '0;
            rx1_i_q     <= '0;
            rx1_q_q     <= '0;
            rx2_i_q     <= '0;
            rx2_q_q     <= '0;
            echo_q      <= '0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            oe_q        <= oe_d;
            bus_q       <= bus_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_cmd_q   <= rsp_cmd_d;
            err_q       <= err_d;
            adc_otr_q   <= adc_otr_d;
            dac_otr_q   <= dac_otr_d;
            adc_min_q   <= adc_min_d;
            adc_max_q   <= adc_max_d;
            rx1_i_q     <= rx1_i_d;
            rx1_q_q     <= rx1_q_d;
            rx2_i_q     <= rx2_i_d;
            rx2_q_q     <= rx2_q_d;
            echo_q      <= echo_d;
            ok_q        <= ok_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign DATA_SYNC    = sync_q;
    assign DATA_BUS_OE  = oe_q;
    assign DATA_BUS_OUT = bus_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_cmd      = rsp_cmd_q;
    assign cmd_error    = err_q;
    assign adc_otr      = adc_otr_q;
    assign dac_otr      = dac_otr_q;
    assign adc_min      = adc_min_q;
    assign adc_max      = adc_max_q;
    assign rx1_i        = rx1_i_q;
    assign rx1_q        = rx1_q_q;
    assign rx2_i        = rx2_i_q;
    assign rx2_q        = rx2_q_q;
    assign bustest_echo = echo_q;
    assign bustest_ok   = ok_q;

endmodule

// File: tb/tb_stm32_bus_master.sv
// Bench for stm32_bus_master: directed commands, a responder model on the bus, and a
// scoreboard monitor that checks every bus byte and completion against queued expectations.
module tb_stm32_bus_master;

    localparam int K_NONE = 0;
    localparam int K_SYNC = 1;
    localparam int K_WB   = 2;
    localparam int K_RSP  = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int           kind;
        logic [7:0]   b;
        logic [2:0]   c;
        logic [127:0] d;
        int           lat;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_code;
    logic [103:0] params_in;
    logic [31:0]  tx_i_in;
    logic [31:0]  tx_q_in;
    logic         DATA_SYNC;
    logic [7:0]   DATA_BUS_OUT;
    logic         DATA_BUS_OE;
    logic [7:0]   DATA_BUS_IN;
    logic         busy;
    logic         rsp_valid;
    logic [2:0]   rsp_cmd;
    logic         cmd_error;
    logic         adc_otr;
    logic         dac_otr;
    logic [15:0]  adc_min;
    logic [15:0]  adc_max;
    logic [31:0]  rx1_i;
    logic [31:0]  rx1_q;
    logic [31:0]  rx2_i;
    logic [31:0]  rx2_q;
    logic [7:0]   bustest_echo;
    logic         bustest_ok;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    logic       resp_drive;
    logic       force_echo;
    logic [7:0] rsp2 [5];
    logic [7:0] exp1 [13];
    logic [7:0] exp3 [8];

    stm32_bus_master #(.IDLE_GAP(1), .BUSTEST_PATTERN(8'hA5)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .params_in    (params_in),
        .tx_i_in      (tx_i_in),
        .tx_q_in      (tx_q_in),
        .DATA_SYNC    (DATA_SYNC),
        .DATA_BUS_OUT (DATA_BUS_OUT),
        .DATA_BUS_OE  (DATA_BUS_OE),
        .DATA_BUS_IN  (DATA_BUS_IN),
        .busy         (busy),
        .rsp_valid    (rsp_valid),
        .rsp_cmd      (rsp_cmd),
        .cmd_error    (cmd_error),
        .adc_otr      (adc_otr),
        .dac_otr      (dac_otr),
        .adc_min      (adc_min),
        .adc_max      (adc_max),
        .rx1_i        (rx1_i),
        .rx1_q        (rx1_q),
        .rx2_i        (rx2_i),
        .rx2_q        (rx2_q),
        .bustest_echo (bustest_echo),
        .bustest_ok   (bustest_ok)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [127:0] rsp_vec(input logic [2:0] c);
        case (c)
            3'd0:    return {119'b0, bustest_ok, bustest_echo};
            3'd2:    return {94'b0, adc_otr, dac_otr, adc_min, adc_max};
            3'd4:    return {rx1_q, rx1_i, rx2_q, rx2_i};
            default: return '0;
        endcase
    endfunction

    task automatic push(input int k, input logic [7:0] b, input logic [2:0] c,
                        input logic [127:0] d, input int lat);
        exp_t e;
        e.kind = k; e.b = b; e.c = c; e.d = d; e.lat = lat;
        sb.push_back(e);
    endtask

    // Responder model: latches the command at the sync strobe and drives read bytes
    // from the second cycle after the command has been sampled.
    initial begin
        int         ph;
        int         idx;
        logic [2:0] rcmd;
        logic [7:0] echo_cap;
        ph = 0; rcmd = 3'd0; echo_cap = 8'h00;
        DATA_BUS_IN = 8'hEE;
        resp_drive  = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst) begin
                ph = 0; resp_drive = 1'b0; DATA_BUS_IN = 8'hEE;
            end else if (DATA_SYNC) begin
                rcmd = DATA_BUS_OUT[2:0]; ph = 1; resp_drive = 1'b0;
            end else if (ph == 1) begin
                echo_cap = DATA_BUS_OUT; ph = 2;
            end else if (ph >= 2) begin
                idx = ph - 2;
                if (rcmd == 3'd4 && idx < 16) begin
                    DATA_BUS_IN = 8'(idx); resp_drive = 1'b1; ph++;
                end else if (rcmd == 3'd2 && idx < 5) begin
                    DATA_BUS_IN = rsp2[idx]; resp_drive = 1'b1; ph++;
                end else if (rcmd == 3'd0 && idx == 0) begin
                    DATA_BUS_IN = force_echo ? 8'h5A : echo_cap; resp_drive = 1'b1; ph++;
                end else begin
                    ph = 0; resp_drive = 1'b0; DATA_BUS_IN = 8'hEE;
                end
            end
        end
    end

    // Monitor: pops one expectation per observed bus byte, completion or error pulse.
    initial begin
        int   cyc;
        int   sync_cyc;
        int   ev;
        exp_t e;
        cyc = 0; sync_cyc = 0;
        forever begin
            @(posedge clk_in); #1;
            cyc++;
            if (!rst) begin
                if (resp_drive) chk("oe_during_read", 128'(DATA_BUS_OE), 128'(0));
                ev = DATA_SYNC ? K_SYNC : DATA_BUS_OE ? K_WB :
                     rsp_valid ? K_RSP : cmd_error ? K_ERR : K_NONE;
                if (ev != K_NONE) begin
                    if (ev == K_SYNC) sync_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_event", 128'(ev), 128'(K_NONE));
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind", 128'(ev), 128'(e.kind));
                        if (e.kind == ev) begin
                            if (ev == K_SYNC)
                                chk("sync_byte", {DATA_BUS_OE, DATA_BUS_OUT}, {1'b1, e.b});
                            if (ev == K_WB)
                                chk("write_byte", 128'(DATA_BUS_OUT), 128'(e.b));
                            if (ev == K_RSP) begin
                                chk("rsp_cmd", 128'(rsp_cmd), 128'(e.c));
                                chk("rsp_data", rsp_vec(e.c), e.d);
                            end
                            if (e.lat >= 0)
                                chk("latency", 128'(cyc - sync_cyc), 128'(e.lat));
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] code, input logic [103:0] p,
                        input logic [31:0] ti, input logic [31:0] tq);
        int g;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(posedge clk_in); #1; g++;
        end
        if (!cmd_ready) chk("ready_timeout", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b1; cmd_code = code; params_in = p; tx_i_in = ti; tx_q_in = tq;
        @(posedge clk_in); #1;
        cmd_valid = 1'b0; cmd_code = 3'd7; params_in = '1; tx_i_in = '1; tx_q_in = '1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            @(posedge clk_in); #1; g++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 128'(sb.size()), 128'(0));
            sb.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_code = 3'd0; params_in = '0;
        tx_i_in = '0; tx_q_in = '0; force_echo = 1'b0;
        exp1 = '{8'h01, 8'h03, 8'hB2, 8'hAB, 8'h03, 8'hB2, 8'hAB,
                 8'h20, 8'h20, 8'h20, 8'h20, 8'hFF, 8'hF6};
        exp3 = '{8'h88, 8'h99, 8'hAA, 8'hBB, 8'h11, 8'h22, 8'h33, 8'h44};
        rsp2 = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};

        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_ctrl", {cmd_ready, busy, DATA_SYNC, DATA_BUS_OE, DATA_BUS_OUT,
                           rsp_valid, rsp_cmd, cmd_error}, '0);
        chk("reset_data", {adc_otr, dac_otr, adc_min, adc_max, bustest_echo, bustest_ok,
                           rx1_i, rx1_q, rx2_i}, '0);
        @(negedge clk_in); rst = 1'b0;
        @(posedge clk_in); #1;
        chk("ready_after_reset", {cmd_ready, busy}, {1'b1, 1'b0});

        push(K_SYNC, 8'h05, 3'd0, '0, 0);
        push(K_RSP, 8'h00, 3'd5, '0, 1);
        send(3'd5, '0, '0, '0);
        drain();

        push(K_SYNC, 8'h01, 3'd0, '0, 0);
        for (int i = 0; i < 13; i++) push(K_WB, exp1[i], 3'd0, '0, i + 1);
        push(K_RSP, 8'h00, 3'd1, '0, 14);
        send(3'd1, 104'h01_03_B2_AB_03_B2_AB_20_20_20_20_FF_F6, '0, '0);
        drain();

        push(K_SYNC, 8'h03, 3'd0, '0, 0);
        for (int i = 0; i < 8; i++) push(K_WB, exp3[i], 3'd0, '0, i + 1);
        push(K_RSP, 8'h00, 3'd3, '0, 9);
        send(3'd3, '0, 32'h11223344, 32'h8899AABB);
        drain();

        push(K_SYNC, 8'h04, 3'd0, '0, 0);
        push(K_RSP, 8'h00, 3'd4, {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F}, 18);
        send(3'd4, '0, '0, '0);
        drain();

        push(K_SYNC, 8'h02, 3'd0, '0, 0);
        push(K_RSP, 8'h00, 3'd2, {94'b0, 1'b0, 1'b1, 16'h1234, 16'h5678}, 7);
        send(3'd2, '0, '0, '0);
        drain();

        push(K_SYNC, 8'h00, 3'd0, '0, 0);
        push(K_WB, 8'hA5, 3'd0, '0, 1);
        push(K_RSP, 8'h00, 3'd0, {119'b0, 1'b1, 8'hA5}, 3);
        send(3'd0, '0, '0, '0);
        drain();

        force_echo = 1'b1;
        push(K_SYNC, 8'h00, 3'd0, '0, 0);
        push(K_WB, 8'hA5, 3'd0, '0, 1);
        push(K_RSP, 8'h00, 3'd0, {119'b0, 1'b0, 8'h5A}, 3);
        send(3'd0, '0, '0, '0);
        drain();
        force_echo = 1'b0;

        push(K_ERR, 8'h00, 3'd7, '0, -1);
        send(3'd7, '0, '0, '0);
        drain();

        push(K_SYNC, 8'h06, 3'd0, '0, 0);
        push(K_RSP, 8'h00, 3'd6, '0, 1);
        send(3'd6, '0, '0, '0);
        drain();

        // Abort a read with reset while byte 6 is on the bus.
        push(K_SYNC, 8'h04, 3'd0, '0, 0);
        send(3'd4, '0, '0, '0);
        repeat (8) @(posedge clk_in);
        @(negedge clk_in); rst = 1'b1;
        @(posedge clk_in); #1;
        chk("abort_bus", {DATA_SYNC, DATA_BUS_OE, DATA_BUS_OUT}, '0);
        chk("abort_rx", {rx1_q, rx1_i, rx2_q, rx2_i}, '0);
        chk("abort_ctrl", {busy, cmd_ready, rsp_valid, cmd_error}, '0);
        chk("abort_sb_empty", 128'(sb.size()), 128'(0));
        sb.delete();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); rst = 1'b0;
        @(posedge clk_in); #1;
        chk("ready_after_abort", 128'(cmd_ready), 128'(1));

        rsp2 = '{8'h03, 8'h80, 8'h01, 8'h7F, 8'hFE};
        push(K_SYNC, 8'h02, 3'd0, '0, 0);
        push(K_RSP, 8'h00, 3'd2, {94'b0, 1'b1, 1'b1, 16'h8001, 16'h7FFE}, 7);
        send(3'd2, '0, '0, '0);
        drain();

        repeat (5) @(posedge clk_in);
        #1;
        chk("final_idle", {cmd_ready, busy, DATA_BUS_OE}, {1'b1, 1'b0, 1'b0});
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
